// File: rtl/shift_engine_n.sv
// Multi-mode shift/rotate engine: LOAD/CLR/NOP complete at once; shifts and rotates
// step one bit per cycle for the latched amount, with carry capture and busy/done status.
module shift_engine_n #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] load_data,
   input  logic             serial_in,
   output logic [WIDTH-1:0] value,
   output logic             carry_out,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OpNop  = 3'b000;
   localparam logic [2:0] OpLoad = 3'b001;
   localparam logic [2:0] OpShl  = 3'b010;
   localparam logic [2:0] OpShr  = 3'b011;
   localparam logic [2:0] OpSar  = 3'b100;
   localparam logic [2:0] OpRol  = 3'b101;
   localparam logic [2:0] OpRor  = 3'b110;
   localparam logic [2:0] OpClr  = 3'b111;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_value, w_value_nxt;
   logic             r_carry, w_carry_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0] w_step_value;
   logic             w_step_carry;

   // One 1-bit step of the latched op; serial_in is read live on every step.
   always_comb begin
      w_step_value = r_value;
      w_step_carry = r_carry;
      case (r_op)
         OpShl: begin
            w_step_value = {r_value[WIDTH-2:0], serial_in};
            w_step_carry = r_value[WIDTH-1];
         end
         OpShr: begin
            w_step_value = {serial_in, r_value[WIDTH-1:1]};
            w_step_carry = r_value[0];
         end
         OpSar: begin
            w_step_value = {r_value[WIDTH-1], r_value[WIDTH-1:1]};
            w_step_carry = r_value[0];
         end
         OpRol: begin
            w_step_value = {r_value[WIDTH-2:0], r_value[WIDTH-1]};
            w_step_carry = r_value[WIDTH-1];
         end
         OpRor: begin
            w_step_value = {r_value[0], r_value[WIDTH-1:1]};
            w_step_carry = r_value[0];
         end
         default: begin
            w_step_value = r_value;
            w_step_carry = r_carry;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_value_nxt = r_value;
      w_carry_nxt = r_carry;
      w_op_nxt    = r_op;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         StIdle: begin
            if (start) begin
               w_op_nxt    = op;
               w_state_nxt = StDone;
               case (op)
                  OpNop:  w_value_nxt = r_value;
                  OpLoad: w_value_nxt = load_data;
                  OpClr: begin
                     w_value_nxt = '0;
                     w_carry_nxt = 1'b0;
                  end
                  default: begin
                     if (amount != '0) begin
                        w_cnt_nxt   = amount;
                        w_state_nxt = StShift;
                     end
                  end
               endcase
            end
         end
         StShift: begin
            w_value_nxt = w_step_value;
            w_carry_nxt = w_step_carry;
            w_cnt_nxt   = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               w_state_nxt = StDone;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
         r_value <= '0;
         r_carry <= 1'b0;
         r_op    <= OpNop;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_value <= w_value_nxt;
         r_carry <= w_carry_nxt;
         r_op    <= w_op_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign value     = r_value;
   assign carry_out = r_carry;
   assign busy      = (r_state == StShift);
   assign done      = (r_state == StDone);

endmodule

// File: tb/tb_shift_engine_n.sv
// Scoreboard bench for shift_engine_n (WIDTH=8): stimulus pushes expected results from an
// arithmetic reference model; a monitor pops and compares on every done pulse.
module tb_shift_engine_n;
   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [AW-1:0] amount;
   logic [W-1:0]  load_data;
   logic          serial_in;
   logic [W-1:0]  value;
   logic          carry_out;
   logic          busy;
   logic          done;

   shift_engine_n #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .amount    (amount),
      .load_data (load_data),
      .serial_in (serial_in),
      .value     (value),
      .carry_out (carry_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] val;
      logic         c;
      int           nb;
   } exp_t;

   exp_t         q[$];
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] m_val = '0;
   logic         m_c   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, want);
      end
   endtask

   // Reference: whole-op result from shift/rotate arithmetic, serial_in held constant.
   task automatic push_exp(input logic [2:0] o, input int k, input logic [W-1:0] ld,
                           input logic si);
      exp_t         e;
      logic [15:0]  w16;
      logic [15:0]  fill;
      w16  = {8'd0, m_val};
      fill = si ? ((16'd1 << k) - 16'd1) : 16'd0;
      e.val = m_val;
      e.c   = m_c;
      e.nb  = 0;
      case (o)
         3'd0: ;
         3'd1: e.val = ld;
         3'd7: begin e.val = '0; e.c = 1'b0; end
         default: if (k > 0) begin
            e.nb = k;
            case (o)
               3'd2: begin e.val = 8'((w16 << k) | fill); e.c = m_val[W-k]; end
               3'd3: begin e.val = 8'((w16 >> k) | (fill << (W-k))); e.c = m_val[k-1]; end
               3'd4: begin e.val = 8'($signed(m_val) >>> k); e.c = m_val[k-1]; end
               3'd5: begin e.val = 8'((w16 << k) | (w16 >> (W-k))); e.c = e.val[0]; end
               default: begin e.val = 8'((w16 >> k) | (w16 << (W-k))); e.c = e.val[W-1]; end
            endcase
         end
      endcase
      m_val = e.val;
      m_c   = e.c;
      q.push_back(e);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_timeout got=0 want=1");
      end
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [2:0] o, input int k, input logic [W-1:0] ld,
                        input logic si);
      push_exp(o, k, ld, si);
      start = 1'b1; op = o; amount = k[AW-1:0]; load_data = ld; serial_in = si;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); amount = AW'($urandom); load_data = W'($urandom);
      wait_done();
   endtask

   // Monitor: counts busy cycles and checks each completion against the scoreboard.
   initial begin
      int   busy_cnt;
      exp_t e;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_cnt = 0;
         end else begin
            if (busy || done) chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (busy) busy_cnt++;
            if (done) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done got=done want=no_done");
               end else begin
                  e = q.pop_front();
                  chk("sb_value", {24'd0, value}, {24'd0, e.val});
                  chk("sb_carry", {31'd0, carry_out}, {31'd0, e.c});
                  chk("sb_busy_cycles", busy_cnt, e.nb);
               end
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin
      logic [W-1:0] steps [3];
      reset = 1'b1; start = 1'b0; op = '0; amount = '0; load_data = '0; serial_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_value", {24'd0, value}, 32'd0);
      chk("rst_carry", {31'd0, carry_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      issue(3'd1, 0, 8'hA5, 1'b0);
      chk("load_a5", {24'd0, value}, 32'h0000_00A5);

      // SHL by 3 with serial_in=1, stepped edge by edge.
      steps[0] = 8'h4B; steps[1] = 8'h97; steps[2] = 8'h2F;
      push_exp(3'd2, 3, 8'h00, 1'b1);
      start = 1'b1; op = 3'd2; amount = 3'd3; serial_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("shl_e0_busy", {31'd0, busy}, 32'd1);
      chk("shl_e0_value", {24'd0, value}, 32'h0000_00A5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("shl_step", {24'd0, value}, {24'd0, steps[i]});
      end
      chk("shl_done", {31'd0, done}, 32'd1);
      chk("shl_carry", {31'd0, carry_out}, 32'd1);
      @(posedge clk); #1;
      chk("shl_done_one_cycle", {31'd0, done}, 32'd0);

      issue(3'd1, 0, 8'h85, 1'b0);
      issue(3'd4, 2, 8'h00, 1'b0);
      chk("sar_value", {24'd0, value}, 32'h0000_00E1);
      chk("sar_carry", {31'd0, carry_out}, 32'd0);

      issue(3'd1, 0, 8'hA5, 1'b0);
      issue(3'd6, 4, 8'h00, 1'b0);
      chk("ror_value", {24'd0, value}, 32'h0000_005A);
      chk("ror_carry", {31'd0, carry_out}, 32'd0);
      issue(3'd5, 0, 8'h00, 1'b0);
      chk("rol0_value", {24'd0, value}, 32'h0000_005A);

      // LOAD pulsed mid-SHR must be ignored.
      push_exp(3'd3, 5, 8'h00, 1'b0);
      start = 1'b1; op = 3'd3; amount = 3'd5; serial_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd1; load_data = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      chk("shr_ignore_load", {24'd0, value}, {24'd0, m_val});

      // start held through DONE: accepted only once back in IDLE.
      issue(3'd1, 0, 8'hC3, 1'b0);
      push_exp(3'd3, 2, 8'h00, 1'b0);
      push_exp(3'd1, 0, 8'h3C, 1'b0);
      start = 1'b1; op = 3'd3; amount = 3'd2; serial_in = 1'b0;
      @(posedge clk); #1;
      op = 3'd1; load_data = 8'h3C;
      for (int n = 0; n < 30 && !done; n++) begin
         @(posedge clk); #1;
      end
      chk("held_first_done", {31'd0, done}, 32'd1);
      @(posedge clk); #1;
      chk("held_ignored_in_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk("held_accepted_done", {31'd0, done}, 32'd1);
      chk("held_load_value", {24'd0, value}, 32'h0000_003C);
      start = 1'b0;
      @(posedge clk); #1;

      // Reset on the 2nd step of SHL by 4.
      push_exp(3'd2, 4, 8'h00, 1'b1);
      start = 1'b1; op = 3'd2; amount = 3'd4; serial_in = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      q.delete();
      @(posedge clk); #1;
      chk("midrst_value", {24'd0, value}, 32'd0);
      chk("midrst_carry", {31'd0, carry_out}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      m_val = '0;
      m_c   = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_done", {31'd0, done}, 32'd0);

      for (int i = 0; i < 60; i++) begin
         issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 7)), W'($urandom),
               1'($urandom_range(0, 1)));
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
